// File: rtl/vga_sync_receiver.sv
// VGA receive front end: locks to incoming h/v sync timing, recovers DE and
// pixel coordinates, re-emits captured RGB and counts lock losses.
module vga_sync_receiver #(
    parameter int   H_VISIBLE  = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_VISIBLE  = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   LOCK_LINES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [3:0]  r_port,
    input  logic [3:0]  g_port,
    input  logic [3:0]  b_port,
    output logic        de,
    output logic [9:0]  x_pixel,
    output logic [9:0]  y_pixel,
    output logic [11:0] rgb_out,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [7:0]  err_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(2 * H_TOTAL);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int LW = $clog2(LOCK_LINES + 1);

    localparam logic [HW-1:0] H_MAX = HW'(2 * H_TOTAL - 1);
    localparam logic [HW-1:0] H_LEN = HW'(H_TOTAL);
    localparam logic [HW-1:0] H_LO  = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_HI  = HW'(H_SYNC + H_BP + H_VISIBLE);
    localparam logic [VW-1:0] V_LEN = VW'(V_TOTAL);
    localparam logic [VW-1:0] V_LO  = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_HI  = VW'(V_SYNC + V_BP + V_VISIBLE);
    localparam logic [LW-1:0] LOCK_C = LW'(LOCK_LINES - 1);

    typedef enum logic [1:0] {
        UNLOCKED,
        H_LOCKED,
        V_MEASURE,
        LOCKED
    } state_t;

    state_t state, state_nxt;

    logic          hs_s, hs_p, vs_s, vs_p;
    logic [11:0]   rgb_s;
    logic [HW-1:0] h_cnt, h_nxt, x_full;
    logic [VW-1:0] v_cnt, v_nxt, y_full;
    logic [LW-1:0] good_cnt;
    logic          h_seen;
    logic          hs_edge, vs_edge, h_timeout;
    logic          line_ok, line_bad, frame_ok;
    logic          drop, lost, vis;

    // Counters describe the sample held in the stage-1 registers.
    always_comb begin
        hs_edge = hs_s & ~hs_p;
        vs_edge = vs_s & ~vs_p;
        if (hs_edge)
            h_nxt = '0;
        else if (h_cnt == H_MAX)
            h_nxt = H_MAX;
        else
            h_nxt = h_cnt + 1'b1;
        if (vs_edge)
            v_nxt = '0;
        else if (hs_edge && v_cnt != '1)
            v_nxt = v_cnt + 1'b1;
        else
            v_nxt = v_cnt;
        h_timeout = (h_nxt == H_MAX);
        line_ok   = hs_edge & h_seen & (h_cnt + 1'b1 == H_LEN);
        line_bad  = hs_edge & h_seen & (h_cnt + 1'b1 != H_LEN);
        frame_ok  = vs_edge & (v_cnt == V_LEN);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= UNLOCKED;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (pix_en) begin
            unique case (state)
                UNLOCKED:
                    if (line_ok && good_cnt == LOCK_C)
                        state_nxt = H_LOCKED;
                H_LOCKED:
                    if (line_bad)
                        state_nxt = UNLOCKED;
                    else if (vs_edge)
                        state_nxt = V_MEASURE;
                V_MEASURE:
                    if (line_bad)
                        state_nxt = UNLOCKED;
                    else if (vs_edge)
                        state_nxt = frame_ok ? LOCKED : UNLOCKED;
                LOCKED:
                    if (line_bad || (vs_edge && !frame_ok))
                        state_nxt = UNLOCKED;
            endcase
            if (h_timeout)
                state_nxt = UNLOCKED;
        end
    end

    always_comb begin
        drop   = pix_en & (state != UNLOCKED) & (state_nxt == UNLOCKED);
        lost   = drop & (state == LOCKED);
        x_full = h_nxt - H_LO;
        y_full = v_nxt - V_LO;
        vis    = (state_nxt == LOCKED)
               & (h_nxt >= H_LO) & (h_nxt < H_HI)
               & (v_nxt >= V_LO) & (v_nxt < V_HI);
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hs_s        <= 1'b0;
            hs_p        <= 1'b0;
            vs_s        <= 1'b0;
            vs_p        <= 1'b0;
            rgb_s       <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_seen      <= 1'b0;
            good_cnt    <= '0;
            de          <= 1'b0;
            x_pixel     <= '0;
            y_pixel     <= '0;
            rgb_out     <= '0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            err_count   <= '0;
        end else begin
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            if (pix_en) begin
                hs_s   <= (h_sync == SYNC_POL);
                hs_p   <= hs_s;
                vs_s   <= (v_sync == SYNC_POL);
                vs_p   <= vs_s;
                rgb_s  <= {r_port, g_port, b_port};
                h_cnt  <= h_nxt;
                v_cnt  <= v_nxt;
                // The first line period after losing lock is never trusted.
                h_seen <= ~drop & (h_seen | hs_edge);
                if (state_nxt != UNLOCKED || drop || line_bad || h_timeout)
                    good_cnt <= '0;
                else if (line_ok)
                    good_cnt <= good_cnt + 1'b1;
                de          <= vis;
                x_pixel     <= vis ? 10'(x_full) : '0;
                y_pixel     <= vis ? 10'(y_full) : '0;
                rgb_out     <= vis ? rgb_s : '0;
                frame_start <= vis && x_full == '0 && y_full == '0;
                if (lost) begin
                    sync_err <= 1'b1;
                    if (err_count != 8'hFF)
                        err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver, run on reduced timings so that
// locking, frames and counter saturation fit in a short simulation.
module tb_vga_sync_receiver;

    localparam logic SYNC_POL = 1'b0;
    localparam int HV = 24, HFP = 2, HS = 4, HBP = 2;
    localparam int VV = 40, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HV + HFP + HS + HBP;
    localparam int VT = VV + VFP + VS + VBP;
    localparam int T_HV = 2, T_HFP = 2, T_HS = 2, T_HBP = 2;
    localparam int T_VV = 1, T_VFP = 1, T_VS = 1, T_VBP = 1;
    localparam int T_HT = T_HV + T_HFP + T_HS + T_HBP;
    localparam int T_VT = T_VV + T_VFP + T_VS + T_VBP;

    logic        clk, reset, pix_en, h_sync, v_sync;
    logic [3:0]  r_port, g_port, b_port;
    logic        de, frame_start, locked, sync_err;
    logic [9:0]  x_pixel, y_pixel;
    logic [11:0] rgb_out;
    logic [7:0]  err_count;

    logic        pix_en2, h_sync2, v_sync2;
    logic [3:0]  r2, g2, b2;
    logic        de2, fs2, locked2, se2;
    logic [9:0]  x2, y2;
    logic [11:0] rgb2;
    logic [7:0]  ec2;

    int checks = 0, errors = 0;
    int hc = 0, vc = 0, line_len = HT;
    int hc2 = 0, vc2 = 0, line_len2 = T_HT;
    bit hs_kill = 0;
    int se_cnt = 0, fs_cnt = 0, de_cnt = 0, se2_cnt = 0;

    vga_sync_receiver #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(SYNC_POL), .LOCK_LINES(4)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .h_sync(h_sync), .v_sync(v_sync),
        .r_port(r_port), .g_port(g_port), .b_port(b_port),
        .de(de), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .rgb_out(rgb_out), .frame_start(frame_start),
        .locked(locked), .sync_err(sync_err), .err_count(err_count)
    );

    vga_sync_receiver #(
        .H_VISIBLE(T_HV), .H_FP(T_HFP), .H_SYNC(T_HS), .H_BP(T_HBP),
        .V_VISIBLE(T_VV), .V_FP(T_VFP), .V_SYNC(T_VS), .V_BP(T_VBP),
        .SYNC_POL(SYNC_POL), .LOCK_LINES(4)
    ) dut_s (
        .clk(clk), .reset(reset), .pix_en(pix_en2),
        .h_sync(h_sync2), .v_sync(v_sync2),
        .r_port(r2), .g_port(g2), .b_port(b2),
        .de(de2), .x_pixel(x2), .y_pixel(y2),
        .rgb_out(rgb2), .frame_start(fs2),
        .locked(locked2), .sync_err(se2), .err_count(ec2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic gen_step(input logic [11:0] rgb);
        h_sync = (!hs_kill && hc >= HV + HFP && hc < HV + HFP + HS)
               ? SYNC_POL : ~SYNC_POL;
        v_sync = (vc >= VV + VFP && vc < VV + VFP + VS)
               ? SYNC_POL : ~SYNC_POL;
        {r_port, g_port, b_port} = rgb;
        @(negedge clk);
        se_cnt += int'(sync_err);
        fs_cnt += int'(frame_start);
        de_cnt += int'(de);
        if (hc >= line_len - 1) begin
            hc = 0;
            line_len = HT;
            vc = (vc == VT - 1) ? 0 : vc + 1;
        end else begin
            hc++;
        end
    endtask

    task automatic gen2_step();
        h_sync2 = (hc2 >= T_HV + T_HFP && hc2 < T_HV + T_HFP + T_HS)
                ? SYNC_POL : ~SYNC_POL;
        v_sync2 = (vc2 >= T_VV + T_VFP && vc2 < T_VV + T_VFP + T_VS)
                ? SYNC_POL : ~SYNC_POL;
        @(negedge clk);
        se2_cnt += int'(se2);
        if (hc2 >= line_len2 - 1) begin
            hc2 = 0;
            line_len2 = T_HT;
            vc2 = (vc2 == T_VT - 1) ? 0 : vc2 + 1;
        end else begin
            hc2++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pix_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            h_sync = i[0];
            v_sync = i[1];
            {r_port, g_port, b_port} = 12'hFFF;
            @(negedge clk);
            checks++;
            if ({de, x_pixel, y_pixel, rgb_out, frame_start, locked,
                 sync_err, err_count} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got de=%b x=%0d y=%0d rgb=%h fs=%b lk=%b se=%b ec=%0d, want all 0",
                         de, x_pixel, y_pixel, rgb_out, frame_start,
                         locked, sync_err, err_count);
            end
        end
        checks++;
        if (locked2 !== 1'b0 || ec2 !== 8'd0) begin
            errors++;
            $display("FAIL reset_small: got locked=%b ec=%0d, want 0 0",
                     locked2, ec2);
        end
        hc = 0;
        vc = 0;
        line_len = HT;
        hs_kill = 0;
        reset = 1'b1;
    endtask

    task automatic test_lock();
        int s0;
        s0 = se_cnt;
        repeat ((VT + VV + VFP) * HT + 1) gen_step(12'h000);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: got locked=%b, want 0", locked);
        end
        gen_step(12'h000);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock: got locked=%b, want 1", locked);
        end
        checks++;
        if (se_cnt != s0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL lock_no_err: got pulses=%0d ec=%0d, want 0 0",
                     se_cnt - s0, err_count);
        end
    endtask

    task automatic test_mapping();
        int n = 0;
        while (!(hc == 17 && vc == 33) && n < 2 * HT * VT) begin
            gen_step(12'h000);
            n++;
        end
        gen_step(12'hA5C);
        gen_step(12'h000);
        checks++;
        if ({de, x_pixel, y_pixel, rgb_out} !==
            {1'b1, 10'd17, 10'd33, 12'hA5C}) begin
            errors++;
            $display("FAIL mapping: got de=%b x=%0d y=%0d rgb=%h, want 1 17 33 a5c",
                     de, x_pixel, y_pixel, rgb_out);
        end
    endtask

    task automatic test_hold();
        pix_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            h_sync = i[0];
            {r_port, g_port, b_port} = 12'(i * 12'h123);
            @(negedge clk);
            checks++;
            if ({de, x_pixel, y_pixel, rgb_out, frame_start} !==
                {1'b1, 10'd17, 10'd33, 12'hA5C, 1'b0}) begin
                errors++;
                $display("FAIL hold: got de=%b x=%0d y=%0d rgb=%h fs=%b, want 1 17 33 a5c 0",
                         de, x_pixel, y_pixel, rgb_out, frame_start);
            end
        end
        pix_en = 1'b1;
        gen_step(12'h000);
        checks++;
        if (x_pixel !== 10'd18 || rgb_out !== 12'h000) begin
            errors++;
            $display("FAIL resume: got x=%0d rgb=%h, want 18 000",
                     x_pixel, rgb_out);
        end
    endtask

    task automatic test_blank();
        int n = 0;
        while (hc != HV && n < 2 * HT) begin
            gen_step(12'h000);
            n++;
        end
        gen_step(12'hFFF);
        gen_step(12'hFFF);
        checks++;
        if ({de, x_pixel, y_pixel, rgb_out} !== '0) begin
            errors++;
            $display("FAIL blank: got de=%b x=%0d y=%0d rgb=%h, want all 0",
                     de, x_pixel, y_pixel, rgb_out);
        end
    endtask

    task automatic test_frame();
        int d0, f0;
        d0 = de_cnt;
        f0 = fs_cnt;
        repeat (HT * VT) gen_step(12'($urandom));
        checks++;
        if (fs_cnt - f0 != 1) begin
            errors++;
            $display("FAIL frame_start_count: got %0d, want 1", fs_cnt - f0);
        end
        checks++;
        if (de_cnt - d0 != HV * VV) begin
            errors++;
            $display("FAIL de_count: got %0d, want %0d", de_cnt - d0, HV * VV);
        end
    endtask

    task automatic test_line_error();
        int s0, n;
        n = 0;
        while (hc != 0 && n < 2 * HT) begin
            gen_step(12'h000);
            n++;
        end
        s0 = se_cnt;
        line_len = HT - 1;
        n = 0;
        while (locked && n < 3 * HT) begin
            gen_step(12'h000);
            n++;
        end
        checks++;
        if (locked !== 1'b0 || se_cnt - s0 != 1 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL line_error: got locked=%b pulses=%0d ec=%0d, want 0 1 1",
                     locked, se_cnt - s0, err_count);
        end
        n = 0;
        while (!locked && n < 4 * HT * VT) begin
            gen_step(12'h000);
            n++;
        end
        checks++;
        if (locked !== 1'b1 || se_cnt - s0 != 1 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL relock: got locked=%b pulses=%0d ec=%0d, want 1 1 1",
                     locked, se_cnt - s0, err_count);
        end
    endtask

    task automatic test_loss();
        int s0, n;
        s0 = se_cnt;
        hs_kill = 1;
        repeat (2 * HT + 8) gen_step(12'h000);
        hs_kill = 0;
        checks++;
        if (locked !== 1'b0 || se_cnt - s0 != 1 || err_count !== 8'd2) begin
            errors++;
            $display("FAIL hs_loss: got locked=%b pulses=%0d ec=%0d, want 0 1 2",
                     locked, se_cnt - s0, err_count);
        end
        n = 0;
        while (!locked && n < 4 * HT * VT) begin
            gen_step(12'h000);
            n++;
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL hs_loss_relock: got locked=%b, want 1", locked);
        end
    endtask

    task automatic test_mid_reset();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({de, x_pixel, y_pixel, rgb_out, locked, sync_err, err_count}
            !== '0) begin
            errors++;
            $display("FAIL mid_reset: got de=%b lk=%b se=%b ec=%0d, want all 0",
                     de, locked, sync_err, err_count);
        end
        hc = 0;
        vc = 0;
        line_len = HT;
        reset = 1'b1;
        test_lock();
    endtask

    task automatic test_saturation();
        int n, want;
        pix_en2 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            n = 0;
            while (!locked2 && n < 20 * T_HT * T_VT) begin
                gen2_step();
                n++;
            end
            n = 0;
            while (hc2 != 0 && n < 2 * T_HT) begin
                gen2_step();
                n++;
            end
            line_len2 = T_HT - 1;
            n = 0;
            while (locked2 && n < 4 * T_HT) begin
                gen2_step();
                n++;
            end
            want = (i + 1 > 255) ? 255 : i + 1;
            checks++;
            if (locked2 !== 1'b0 || int'(ec2) != want) begin
                errors++;
                $display("FAIL saturate_step%0d: got locked=%b ec=%0d, want 0 %0d",
                         i, locked2, ec2, want);
            end
        end
        checks++;
        if (ec2 !== 8'd255 || se2_cnt != 300) begin
            errors++;
            $display("FAIL saturate_final: got ec=%0d pulses=%0d, want 255 300",
                     ec2, se2_cnt);
        end
    endtask

    initial begin
        reset = 1'b0;
        pix_en = 1'b1;
        h_sync = ~SYNC_POL;
        v_sync = ~SYNC_POL;
        {r_port, g_port, b_port} = '0;
        pix_en2 = 1'b1;
        h_sync2 = ~SYNC_POL;
        v_sync2 = ~SYNC_POL;
        {r2, g2, b2} = '0;
        @(negedge clk);
        test_reset();
        test_lock();
        test_mapping();
        test_hold();
        test_blank();
        test_frame();
        test_line_error();
        test_loss();
        test_mid_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
